bcd_scan_dec: RTL and testbench
===============================

// Module: bcd_scan_dec
// PURPOSE
//  Multi-digit BCD-to-7-segment decoder with time-multiplexed digit scanning.
//  Reverse path of the switch-to-BCD encoder: takes packed BCD digits and drives
//  a common-segment LED display one digit at a time.
//  Sits between the BCD value producers and the board's display pins.
// PARAMETERS
//  DIGITS     4     number of BCD digits scanned; legal range 1..8
//  PRESCALE   1000  CLK cycles per digit slot; must be >= BLANK_CYC+2
//  BLANK_CYC  2     anti-ghost cycles at the start of each slot with DIG_SEL=0
// PORTS
//  CLK       in   1          single system clock, rising edge
//  RST       in   1          asynchronous reset, active-high
//  LOAD      in   1          sample BCD_IN this cycle
//  BCD_IN    in   4*DIGITS   packed BCD; digit i = BCD_IN[4i+3:4i]; digit 0 is LS
//  BLANK_LZ  in   1          1 = suppress leading zeros (digit 0 never suppressed)
//  SEG_OUT   out  7          segments {g,f,e,d,c,b,a}, active-high, registered
//  DIG_SEL   out  DIGITS     one-hot digit enable, active-high, registered
//  ERR       out  1          level: some displayed digit is >9, registered
//  FRAME     out  1          1-cycle pulse when a new frame's data takes effect
// BEHAVIOUR
//  Reset (async, RST=1): all of the following clear to 0 immediately and stay 0
//   while RST is high: cnt, idx, pend, disp, SEG_OUT, DIG_SEL, ERR, FRAME.
//  Counters:
//   - cnt runs 0..PRESCALE-1 and wraps.
//   - On cnt==PRESCALE-1, idx advances 0..DIGITS-1, wrapping to 0.
//   - wrap = (cnt==PRESCALE-1 && idx==DIGITS-1).
//  Loading, double-buffered, so the display never tears mid-frame:
//   - LOAD=1 without wrap: pend<=BCD_IN. disp is unchanged.
//   - wrap without LOAD: disp<=pend.
//   - wrap and LOAD in the same cycle: pend<=BCD_IN and disp<=BCD_IN.
//   - LOAD held high: BCD_IN is re-sampled every cycle; the last value wins.
//  Outputs: registered from the current cnt/idx/disp. Each output lags its state
//   by 1 cycle.
//   - DIG_SEL <= (cnt<BLANK_CYC) ? 0 : onehot(idx).
//   - SEG_OUT <= (cnt<BLANK_CYC || suppressed(idx)) ? 0 : dec(disp[idx]).
//   - suppressed(i) = BLANK_LZ && i!=0 && every disp digit j>=i equals 0.
//   - A suppressed digit keeps DIG_SEL active and drives SEG_OUT=0.
//  Decode table dec(), hex values of {g..a}:
//   - 0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07  8:7F  9:6F
//   - 10..15: 40 (dash, segment g only).
//  Status outputs:
//   - ERR <= OR over disp digits of (digit>9). ERR updates 1 cycle after disp.
//   - FRAME <= wrap. FRAME is high during the first cycle of the new frame,
//     i.e. idx==0 and cnt==0.
//  Timing:
//   - Frame period = DIGITS*PRESCALE cycles.
//   - DIG_SEL per-slot low time = BLANK_CYC cycles; never two bits set at once.
//  RST asserted mid-frame: the scan restarts at digit 0 slot start. The pending
//   load is lost.
// TESTING (DIGITS=4, PRESCALE=4, BLANK_CYC=1 unless noted)
//  1 Reset: assert RST mid-slot.
//    -> SEG_OUT, DIG_SEL, ERR, FRAME = 0 without waiting for a CLK edge.
//    On release, the first DIG_SEL=0001 appears 2 cycles later.
//  2 Decode: LOAD BCD_IN=16'h1234, BLANK_LZ=0, then wait for FRAME.
//    -> slots show DIG_SEL/SEG_OUT = 0001/66, 0010/4F, 0100/5B, 1000/06.
//    FRAME repeats every 16 cycles.
//  3 Leading-zero suppression: BLANK_LZ=1, load 16'h0005.
//    -> digit 0 = 6D; digits 1..3 have SEG_OUT=00 with DIG_SEL still active.
//    Then load 16'h0000 -> digit 0 = 3F.
//    Then load 16'h0105 -> digit 1 = 3F, digit 3 blank.
//  4 Invalid code: load 16'h00A9.
//    -> after FRAME, digit 1 SEG_OUT=40, digit 0 SEG_OUT=6F, ERR=1.
//    Reload 16'h0009 -> ERR=0 one frame later.
//  5 Buffering and collision:
//    - LOAD 16'h1111 mid-frame -> the current frame still shows the old value;
//      the next frame shows 06 on all digits.
//    - LOAD 16'h2222 on the wrap cycle -> the very next frame shows 5B.
//  6 Blanking and one-hot: PRESCALE=6, BLANK_CYC=2.
//    -> DIG_SEL is 0 for exactly 2 cycles at each slot start.
//    -> $onehot0(DIG_SEL) holds on every cycle over 100 frames with random LOAD.

Source files
------------

// File: rtl/bcd_scan_dec.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_dec
// Description : Multi-digit BCD to 7-segment decoder with time-multiplexed
//               digit scanning for a common-segment LED display. Incoming
//               BCD values are double-buffered so that a frame never tears.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous reset, active-high
//               load     - sample bcd_in this cycle
//               bcd_in   - packed BCD, digit i = bcd_in[4i+3:4i], digit 0 LS
//               blank_lz - suppress leading zeros (digit 0 never suppressed)
//               seg_out  - segments {g,f,e,d,c,b,a}, active-high, registered
//               dig_sel  - one-hot digit enable, active-high, registered
//               err      - some displayed digit is above 9, registered
//               frame    - 1-cycle pulse when a new frame's data takes effect
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_dec #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  err,
  output logic                  frame
);

  localparam int c_CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(PRESCALE - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DIGITS - 1);
  localparam logic [c_CW-1:0] c_BLANK    = c_CW'(BLANK_CYC);

  logic [c_CW-1:0]       r_cnt;
  logic [c_IW-1:0]       r_idx;
  logic [4*DIGITS-1:0]   r_pend;
  logic [4*DIGITS-1:0]   r_disp;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_blank;
  logic [3:0]            w_cur;
  logic                  w_tail_zero;
  logic                  w_sup;
  logic                  w_err;
  logic [DIGITS-1:0]     w_onehot;

  // Segment pattern {g,f,e,d,c,b,a}; any non-decimal code shows a dash.
  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign w_slot_end = (r_cnt == c_CNT_LAST);
  assign w_wrap     = w_slot_end && (r_idx == c_IDX_LAST);
  // Anti-ghost window: all digits off while the segment drivers settle.
  assign w_blank    = (r_cnt < c_BLANK);
  assign w_onehot   = DIGITS'(1) << r_idx;

  // Digit currently being scanned.
  always_comb begin
    w_cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_cur = r_disp[4*i +: 4];
      end
    end
  end

  // Walk from the most significant digit downwards; a digit is a leading
  // zero when it and every digit above it are zero. Digit 0 is excluded.
  always_comb begin
    w_tail_zero = 1'b1;
    w_sup       = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_tail_zero = w_tail_zero & (r_disp[4*i +: 4] == 4'd0);
      if (r_idx == c_IW'(i)) begin
        w_sup = w_tail_zero;
      end
    end
    w_sup = w_sup & blank_lz;
  end

  // Any displayed digit in 10..15.
  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_err = w_err | (r_disp[4*i + 3] & (r_disp[4*i + 2] | r_disp[4*i + 1]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
      r_disp  <= '0;
      seg_out <= '0;
      dig_sel <= '0;
      err     <= 1'b0;
      frame   <= 1'b0;
    end else begin
      // Scan counters
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Double buffer: the displayed value only changes at a frame boundary.
      // A load coinciding with the boundary goes straight to the display.
      if (load) begin
        r_pend <= bcd_in;
      end
      if (w_wrap) begin
        r_disp <= load ? bcd_in : r_pend;
      end

      // Registered outputs
      dig_sel <= w_blank ? '0 : w_onehot;
      seg_out <= (w_blank || w_sup) ? 7'h00 : dec(w_cur);
      err     <= w_err;
      frame   <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_scan_dec
// Description : Self-checking bench for bcd_scan_dec. A cycle model produces
//               the expected outputs of the DIGITS=4/PRESCALE=4/BLANK_CYC=1
//               instance into a scoreboard; directed checks cover decode,
//               suppression, buffering and reset. A second instance with
//               PRESCALE=6/BLANK_CYC=2 is checked for blanking and one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_dec;

  localparam int D = 4;
  localparam int P = 4;
  localparam int B = 1;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;

  logic [6:0]  seg4;
  logic [3:0]  dig4;
  logic        err4;
  logic        frame4;
  logic [6:0]  seg6;
  logic [3:0]  dig6;
  logic        err6;
  logic        frame6;

  int nvec;
  int nmis;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       err;
    logic       frame;
  } exp_t;

  exp_t sb[$];

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_pend;
  logic [15:0] m_disp;

  int          run6;
  logic [3:0]  prev6;

  bcd_scan_dec #(.DIGITS(D), .PRESCALE(P), .BLANK_CYC(B)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .seg_out  (seg4),
    .dig_sel  (dig4),
    .err      (err4),
    .frame    (frame4)
  );

  bcd_scan_dec #(.DIGITS(4), .PRESCALE(6), .BLANK_CYC(2)) u_dut6 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .seg_out  (seg6),
    .dig_sel  (dig6),
    .err      (err6),
    .frame    (frame6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic sup_ref(input int i, input logic [15:0] d, input logic blz);
    if (!blz || i == 0) return 1'b0;
    for (int j = i; j < D; j++) begin
      if (d[4*j +: 4] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_pend = '0;
    m_disp = '0;
    run6   = 0;
    prev6  = '0;
  endtask

  // One clock cycle: model predicts, scoreboard compares after the edge.
  task automatic step();
    exp_t e;
    logic wrap;
    @(posedge clk);
    if (rst) begin
      model_reset();
      e = '0;
    end else begin
      wrap    = (m_cnt == P - 1) && (m_idx == D - 1);
      e.dig   = (m_cnt < B) ? 4'b0000 : (4'b0001 << m_idx);
      e.seg   = ((m_cnt < B) || sup_ref(m_idx, m_disp, blank_lz)) ? 7'h00
                : dec_ref(m_disp[4*m_idx +: 4]);
      e.err   = 1'b0;
      for (int j = 0; j < D; j++) begin
        if (m_disp[4*j +: 4] > 4'd9) e.err = 1'b1;
      end
      e.frame = wrap;
      if (load) m_pend = bcd_in;
      if (wrap) m_disp = load ? bcd_in : m_pend;
      if (m_cnt == P - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % D;
      end else begin
        m_cnt++;
      end
    end
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("sb_seg", {25'd0, seg4}, {25'd0, e.seg});
    chk("sb_dig", {28'd0, dig4}, {28'd0, e.dig});
    chk("sb_err", {31'd0, err4}, {31'd0, e.err});
    chk("sb_frame", {31'd0, frame4}, {31'd0, e.frame});
    chk("onehot6", {31'd0, $onehot0(dig6)}, 32'd1);
    if (!rst) begin
      if (dig6 == 4'b0000) begin
        run6++;
      end else begin
        if (run6 != 0) chk("blank_run6", run6, 2);
        if (prev6 != 4'b0000) chk("slot_hold6", {28'd0, dig6}, {28'd0, prev6});
        run6 = 0;
      end
      prev6 = dig6;
    end
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_val(input logic [15:0] v);
    load   = 1'b1;
    bcd_in = v;
    step();
    load   = 1'b0;
  endtask

  // Returns with frame4 high (state: digit 0, cnt 0), bounded.
  task automatic wait_frame(input string tag);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      step();
      n++;
      if (frame4) got = 1'b1;
    end
    chk({tag, "_frame_seen"}, {31'd0, got}, 32'd1);
  endtask

  // Called right after a frame pulse; checks the middle of each slot.
  task automatic chk_slots(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    step_n(2);
    chk({tag, "_dig0"}, {28'd0, dig4}, 32'h1);
    chk({tag, "_seg0"}, {25'd0, seg4}, {25'd0, s0});
    step_n(4);
    chk({tag, "_dig1"}, {28'd0, dig4}, 32'h2);
    chk({tag, "_seg1"}, {25'd0, seg4}, {25'd0, s1});
    step_n(4);
    chk({tag, "_dig2"}, {28'd0, dig4}, 32'h4);
    chk({tag, "_seg2"}, {25'd0, seg4}, {25'd0, s2});
    step_n(4);
    chk({tag, "_dig3"}, {28'd0, dig4}, 32'h8);
    chk({tag, "_seg3"}, {25'd0, seg4}, {25'd0, s3});
  endtask

  initial begin
    int per;
    nvec     = 0;
    nmis     = 0;
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    blank_lz = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state and release timing
    step_n(2);
    chk("rst_seg", {25'd0, seg4}, 32'd0);
    chk("rst_dig", {28'd0, dig4}, 32'd0);
    chk("rst_err", {31'd0, err4}, 32'd0);
    chk("rst_frame", {31'd0, frame4}, 32'd0);
    rst = 1'b0;
    step();
    chk("rel_dig_c1", {28'd0, dig4}, 32'h0);
    step();
    chk("rel_dig_c2", {28'd0, dig4}, 32'h1);

    // Async reset mid-slot, with a pending load that must be lost
    load_val(16'h1234);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_seg", {25'd0, seg4}, 32'd0);
    chk("async_dig", {28'd0, dig4}, 32'd0);
    chk("async_dig6", {28'd0, dig6}, 32'd0);
    chk("async_err", {31'd0, err4}, 32'd0);
    chk("async_frame", {31'd0, frame4}, 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    step();
    chk("restart_c1", {28'd0, dig4}, 32'h0);
    step();
    chk("restart_c2", {28'd0, dig4}, 32'h1);
    wait_frame("lost");
    chk_slots("lost", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // Decode and frame period
    load_val(16'h1234);
    wait_frame("dec");
    chk_slots("dec", 7'h66, 7'h4F, 7'h5B, 7'h06);
    wait_frame("per_a");
    per = 0;
    do begin
      step();
      per++;
    end while (!frame4 && per < 40);
    chk("frame_period", per, 16);

    // Leading-zero suppression
    blank_lz = 1'b1;
    load_val(16'h0005);
    wait_frame("lz5");
    chk_slots("lz5", 7'h6D, 7'h00, 7'h00, 7'h00);
    load_val(16'h0000);
    wait_frame("lz0");
    chk_slots("lz0", 7'h3F, 7'h00, 7'h00, 7'h00);
    load_val(16'h0105);
    wait_frame("lz105");
    chk_slots("lz105", 7'h6D, 7'h3F, 7'h06, 7'h00);

    // Invalid code and ERR lag
    blank_lz = 1'b0;
    load_val(16'h00A9);
    wait_frame("inv");
    chk("inv_err_lag", {31'd0, err4}, 32'd0);
    chk_slots("inv", 7'h6F, 7'h40, 7'h3F, 7'h3F);
    chk("inv_err", {31'd0, err4}, 32'd1);
    load_val(16'h0009);
    wait_frame("ok");
    step();
    chk("ok_err", {31'd0, err4}, 32'd0);

    // Mid-frame load does not tear the current frame
    wait_frame("buf");
    step_n(3);
    load_val(16'h1111);
    step_n(2);
    chk("buf_old_dig", {28'd0, dig4}, 32'h2);
    chk("buf_old_seg", {25'd0, seg4}, 32'h3F);
    wait_frame("buf_new");
    chk_slots("buf_new", 7'h06, 7'h06, 7'h06, 7'h06);

    // Load on the wrap cycle reaches the display immediately
    step();
    load_val(16'h2222);
    chk("coll_frame", {31'd0, frame4}, 32'd1);
    chk_slots("coll", 7'h5B, 7'h5B, 7'h5B, 7'h5B);

    // Random traffic: 100 frames of the PRESCALE=6 instance
    for (int k = 0; k < 2400; k++) begin
      load     = ($urandom_range(0, 7) == 0);
      bcd_in   = 16'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
      step();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
